// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-rate divider, H/V pixel counters and
// a registered sync/colour pin stage that trails the counters by one pixel.
module vga_sync_gen #(
  parameter int DIV    = 2,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] D_MAX = DW'(DIV - 1);

  localparam logic [9:0] H_MAX      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_d;

  logic       w_hWrap;
  logic       w_vWrap;
  logic [9:0] w_hNext;
  logic [9:0] w_vNext;
  logic       w_videoNext;
  logic       w_hsyncNext;
  logic       w_vsyncNext;

  // The divider is the only state that moves between pixel ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
    end else if (pixel_tick) begin
      r_d <= '0;
    end else begin
      r_d <= r_d + 1'b1;
    end
  end

  assign pixel_tick = (r_d == D_MAX);

  always_comb begin
    w_hWrap     = (HCount == H_MAX);
    w_vWrap     = (VCount == V_MAX);
    w_hNext     = w_hWrap ? 10'd0 : HCount + 10'd1;
    w_vNext     = VCount;
    if (w_hWrap) begin
      w_vNext = w_vWrap ? 10'd0 : VCount + 10'd1;
    end
    w_videoNext = (w_hNext < H_VIS_L) && (w_vNext < V_VIS_L);
    w_hsyncNext = !((HCount >= HS_FIRST) && (HCount <= HS_LAST));
    w_vsyncNext = !((VCount >= VS_FIRST) && (VCount <= VS_LAST));
  end

  assign frame_start = pixel_tick && w_hWrap && w_vWrap;

  // Counters reset to the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      HCount   <= H_MAX;
      VCount   <= V_MAX;
      video_on <= 1'b0;
    end else if (pixel_tick) begin
      HCount   <= w_hNext;
      VCount   <= w_vNext;
      video_on <= w_videoNext;
    end
  end

  // Pins decode the pre-edge counters, giving one pixel of shared lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 3'b000;
    end else if (pixel_tick) begin
      hsync <= w_hsyncNext;
      vsync <= w_vsyncNext;
      rgb   <= video_on ? rgb_in : 3'b000;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default DIV=2, default DIV=1, small
// geometry DIV=3) each checked by a scoreboard fed from a linear-pixel-index model.
module tb_vga_sync_gen;

  localparam int DIVS[3] = '{2, 1, 3};
  localparam int HVIS[3] = '{640, 640, 10};
  localparam int HFP[3]  = '{16, 16, 2};
  localparam int HSY[3]  = '{96, 96, 3};
  localparam int HBP[3]  = '{48, 48, 4};
  localparam int VVIS[3] = '{480, 480, 6};
  localparam int VFP[3]  = '{10, 10, 2};
  localparam int VSY[3]  = '{2, 2, 2};
  localparam int VBP[3]  = '{33, 33, 3};

  typedef struct packed {
    logic       rst;
    logic       win;
    logic       tick;
    logic       fs;
    logic [9:0] h;
    logic [9:0] v;
    logic       von;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstSig [3];
  logic [2:0] rgbIn  [3];
  logic [9:0] hc     [3];
  logic [9:0] vc     [3];
  logic       von    [3];
  logic       tk     [3];
  logic       fsv    [3];
  logic       hsy    [3];
  logic       vsy    [3];
  logic [2:0] rgbo   [3];

  vga_sync_gen #(.DIV(DIVS[0])) dutA (
    .clk(clk), .reset(rstSig[0]), .rgb_in(rgbIn[0]), .HCount(hc[0]), .VCount(vc[0]),
    .video_on(von[0]), .pixel_tick(tk[0]), .frame_start(fsv[0]), .hsync(hsy[0]),
    .vsync(vsy[0]), .rgb(rgbo[0]));

  vga_sync_gen #(.DIV(DIVS[1])) dutB (
    .clk(clk), .reset(rstSig[1]), .rgb_in(rgbIn[1]), .HCount(hc[1]), .VCount(vc[1]),
    .video_on(von[1]), .pixel_tick(tk[1]), .frame_start(fsv[1]), .hsync(hsy[1]),
    .vsync(vsy[1]), .rgb(rgbo[1]));

  vga_sync_gen #(
    .DIV(DIVS[2]), .H_VIS(HVIS[2]), .H_FP(HFP[2]), .H_SYNC(HSY[2]), .H_BP(HBP[2]),
    .V_VIS(VVIS[2]), .V_FP(VFP[2]), .V_SYNC(VSY[2]), .V_BP(VBP[2])
  ) dutC (
    .clk(clk), .reset(rstSig[2]), .rgb_in(rgbIn[2]), .HCount(hc[2]), .VCount(vc[2]),
    .video_on(von[2]), .pixel_tick(tk[2]), .frame_start(fsv[2]), .hsync(hsy[2]),
    .vsync(vsy[2]), .rgb(rgbo[2]));

  int checks = 0;
  int errors = 0;

  expT q0[$];
  expT q1[$];
  expT q2[$];

  int         curPos  [3];
  int         clkN    [3];
  logic       pinHs   [3];
  logic       pinVs   [3];
  logic [2:0] pinRgb  [3];
  logic       running [3] = '{1'b1, 1'b1, 1'b1};
  logic       monDone [3] = '{1'b0, 1'b0, 1'b0};

  int stTicks [3] = '{0, 0, 0};
  int stFs    [3] = '{0, 0, 0};
  int stHsLow [3] = '{0, 0, 0};
  int stVsLow [3] = '{0, 0, 0};
  int stRgbOn [3] = '{0, 0, 0};

  function automatic int hTot(input int k);
    return HVIS[k] + HFP[k] + HSY[k] + HBP[k];
  endfunction

  function automatic int vTot(input int k);
    return VVIS[k] + VFP[k] + VSY[k] + VBP[k];
  endfunction

  function automatic logic visible(input int k, input int pos);
    return ((pos % hTot(k)) < HVIS[k]) && ((pos / hTot(k)) < VVIS[k]);
  endfunction

  function automatic logic inHsync(input int k, input int pos);
    int h = pos % hTot(k);
    return (h >= HVIS[k] + HFP[k]) && (h < HVIS[k] + HFP[k] + HSY[k]);
  endfunction

  function automatic logic inVsync(input int k, input int pos);
    int v = pos / hTot(k);
    return (v >= VVIS[k] + VFP[k]) && (v < VVIS[k] + VFP[k] + VSY[k]);
  endfunction

  task automatic pushExp(input int k, input expT e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qSize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic popExp(input int k, output expT e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic checkOutput(input logic ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: %s", name, detail);
    end
  endtask

  // Drives one clock of stimulus and queues what the pins must show after it.
  task automatic applyStimulus(input int k, input logic r, input logic [2:0] c, input logic w);
    expT e;
    int  total = hTot(k) * vTot(k);
    rstSig[k] = r;
    rgbIn[k]  = c;
    e.rst  = r;
    e.win  = w;
    e.tick = 1'b0;
    e.fs   = 1'b0;
    if (r) begin
      clkN[k]   = 0;
      curPos[k] = total - 1;
      pinHs[k]  = 1'b1;
      pinVs[k]  = 1'b1;
      pinRgb[k] = 3'b000;
    end else begin
      e.tick = ((clkN[k] % DIVS[k]) == DIVS[k] - 1);
      e.fs   = e.tick && (curPos[k] == total - 1);
      if (e.tick) begin
        pinHs[k]  = !inHsync(k, curPos[k]);
        pinVs[k]  = !inVsync(k, curPos[k]);
        pinRgb[k] = visible(k, curPos[k]) ? c : 3'b000;
        curPos[k] = (curPos[k] + 1) % total;
      end
      clkN[k]++;
    end
    e.h   = 10'(curPos[k] % hTot(k));
    e.v   = 10'(curPos[k] / hTot(k));
    e.von = visible(k, curPos[k]);
    e.hs  = pinHs[k];
    e.vs  = pinVs[k];
    e.rgb = pinRgb[k];
    pushExp(k, e);
  endtask

  task automatic monitor(input int k);
    expT  e;
    logic tickSeen;
    forever begin
      @(negedge clk);
      #1;
      if (!running[k] && qSize(k) == 0) break;
      if (qSize(k) == 0) begin
        checkOutput(1'b0, $sformatf("sbEmpty%0d", k), "scoreboard empty while stimulus running");
        break;
      end
      popExp(k, e);
      tickSeen = tk[k];
      if (!e.rst) begin
        checkOutput(tk[k] === e.tick && fsv[k] === e.fs, $sformatf("strobe%0d", k),
          $sformatf("got tick=%b fs=%b, want tick=%b fs=%b at clk %0d",
                    tk[k], fsv[k], e.tick, e.fs, clkN[k]));
        if (e.win) begin
          if (tk[k] === 1'b1) stTicks[k]++;
          if (fsv[k] === 1'b1) stFs[k]++;
        end
      end
      @(posedge clk);
      #1;
      checkOutput(hc[k] === e.h && vc[k] === e.v && von[k] === e.von && hsy[k] === e.hs &&
                  vsy[k] === e.vs && rgbo[k] === e.rgb, $sformatf("regs%0d", k),
        $sformatf("got h=%0d v=%0d von=%b hs=%b vs=%b rgb=%b, want h=%0d v=%0d von=%b hs=%b vs=%b rgb=%b",
                  hc[k], vc[k], von[k], hsy[k], vsy[k], rgbo[k],
                  e.h, e.v, e.von, e.hs, e.vs, e.rgb));
      if (e.win && tickSeen === 1'b1) begin
        if (hsy[k] === 1'b0) stHsLow[k]++;
        if (vsy[k] === 1'b0) stVsLow[k]++;
        if (rgbo[k] === 3'b111) stRgbOn[k]++;
      end
    end
    monDone[k] = 1'b1;
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Default geometry at DIV=2: reset release, then random colour for four lines.
  initial begin
    rstSig[0] = 1'b1;
    rgbIn[0]  = 3'b000;
    repeat (3) begin @(negedge clk); applyStimulus(0, 1'b1, 3'b000, 1'b0); end
    for (int i = 0; i < 1602; i++) begin
      @(negedge clk); applyStimulus(0, 1'b0, 3'($urandom), 1'b1);
    end
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk); applyStimulus(0, 1'b0, 3'($urandom), 1'b0);
    end
    @(negedge clk);
    running[0] = 1'b0;
  end

  // Default geometry at DIV=1 with white input over one full line.
  initial begin
    rstSig[1] = 1'b1;
    rgbIn[1]  = 3'b000;
    repeat (3) begin @(negedge clk); applyStimulus(1, 1'b1, 3'b000, 1'b0); end
    for (int i = 0; i < 801; i++) begin
      @(negedge clk); applyStimulus(1, 1'b0, 3'b111, 1'b1);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); applyStimulus(1, 1'b0, 3'($urandom), 1'b0);
    end
    @(negedge clk);
    running[1] = 1'b0;
  end

  // Small geometry at DIV=3: three whole frames, then reset inside both sync pulses.
  initial begin
    rstSig[2] = 1'b1;
    rgbIn[2]  = 3'b000;
    repeat (2) begin @(negedge clk); applyStimulus(2, 1'b1, 3'b000, 1'b0); end
    for (int i = 0; i < 3 * (3 * hTot(2) * vTot(2) + 1); i++) begin
      @(negedge clk); applyStimulus(2, 1'b0, 3'($urandom), 1'b1);
    end
    while (curPos[2] != 9 * hTot(2) + 13) begin
      @(negedge clk); applyStimulus(2, 1'b0, 3'($urandom), 1'b0);
    end
    @(negedge clk);
    checkOutput(hsy[2] === 1'b0 && vsy[2] === 1'b0, "cSyncLowBeforeReset",
      $sformatf("got hs=%b vs=%b, want hs=0 vs=0", hsy[2], vsy[2]));
    applyStimulus(2, 1'b1, 3'b111, 1'b0);
    @(posedge clk);
    #1;
    checkOutput(hc[2] === 10'd18 && vc[2] === 10'd12 && hsy[2] === 1'b1 && vsy[2] === 1'b1 &&
                rgbo[2] === 3'b000 && von[2] === 1'b0, "cMidFrameReset",
      $sformatf("got h=%0d v=%0d hs=%b vs=%b rgb=%b von=%b, want h=18 v=12 hs=1 vs=1 rgb=000 von=0",
                hc[2], vc[2], hsy[2], vsy[2], rgbo[2], von[2]));
    repeat (2) begin @(negedge clk); applyStimulus(2, 1'b1, 3'b000, 1'b0); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); applyStimulus(2, 1'b0, 3'($urandom), 1'b0);
    end
    @(negedge clk);
    running[2] = 1'b0;
  end

  // Waits for all monitors, then checks the per-window timing totals.
  initial begin
    int budget = 0;
    while (!(monDone[0] && monDone[1] && monDone[2]) && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput(monDone[0] && monDone[1] && monDone[2], "timeout",
      $sformatf("monitors done %b%b%b after %0d clks, want 111",
                monDone[0], monDone[1], monDone[2], budget));
    checkOutput(stTicks[0] == 801, "aTicks", $sformatf("got %0d, want 801", stTicks[0]));
    checkOutput(stHsLow[0] == 96, "aHsyncLow", $sformatf("got %0d, want 96", stHsLow[0]));
    checkOutput(stTicks[1] == 801, "bTickAlwaysHigh", $sformatf("got %0d, want 801", stTicks[1]));
    checkOutput(stHsLow[1] == 96, "bHsyncLow", $sformatf("got %0d, want 96", stHsLow[1]));
    checkOutput(stRgbOn[1] == 640, "bRgbOn", $sformatf("got %0d, want 640", stRgbOn[1]));
    checkOutput(stTicks[2] == 742, "cTicks", $sformatf("got %0d, want 742", stTicks[2]));
    checkOutput(stFs[2] == 4, "cFrameStarts", $sformatf("got %0d, want 4", stFs[2]));
    checkOutput(stVsLow[2] == 114, "cVsyncLow", $sformatf("got %0d, want 114", stVsLow[2]));
    checkOutput(stHsLow[2] == 117, "cHsyncLow", $sformatf("got %0d, want 117", stHsLow[2]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 timing generator and output pipeline for the card display. Divides the system clock into a pixel-rate tick and runs the horizontal/vertical pixel counters that every card renderer decodes. Merges the renderers' combined 3-bit colour back in and drives the registered hsync, vsync and rgb pins, all aligned.

## Interface

Parameters:
- DIV, 2: system clocks per pixel; 50 MHz gives a 25 MHz pixel rate. Must be >= 1.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync pulse width.
- H_BP, 48: horizontal back porch.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync pulse width.
- V_BP, 33: vertical back porch.
- Derived: H_TOTAL = 800 and V_TOTAL = 525 with the defaults.

Ports:
- clk, in, 1: system clock. One clock domain only.
- reset, in, 1: synchronous, active-high.
- rgb_in, in, 3: colour for the current HCount/VCount, combinational from the renderers (OR of card rgb outputs). Bit 2 is red.
- HCount, out, 10: current pixel column, 0..H_TOTAL-1, registered.
- VCount, out, 10: current line, 0..V_TOTAL-1, registered.
- video_on, out, 1: high when HCount < H_VIS and VCount < V_VIS. Registered and aligned with the counters.
- pixel_tick, out, 1: one-clk strobe; counters advance at the edge that ends this cycle.
- frame_start, out, 1: one-clk strobe on the tick that wraps the counters to (0,0).
- hsync, out, 1: active-low horizontal sync pin, registered.
- vsync, out, 1: active-low vertical sync pin, registered.
- rgb, out, 3: colour pin, registered, forced to 0 outside the visible area.

## Operation

- Divider: internal d counts 0..DIV-1 and wraps. pixel_tick = (d == DIV-1). With DIV = 1, pixel_tick is constantly 1 after reset.
- Stage 0 (counters), updated only on an edge where pixel_tick = 1:
  - HCount = (HCount == H_TOTAL-1) ? 0 : HCount+1.
  - VCount increments only when HCount wraps. VCount wraps to 0 after V_TOTAL-1.
  - video_on is recomputed from the next counter values, so it always matches the HCount/VCount being presented.
- frame_start = pixel_tick and HCount == H_TOTAL-1 and VCount == V_TOTAL-1.
- Stage 1 (pins), updated on the same tick edge, from the stage-0 values current before the edge:
  - hsync = 0 if HCount is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751; otherwise 1.
  - vsync = 0 if VCount is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491; otherwise 1.
  - rgb = video_on ? rgb_in : 3'b000.
- Result: the pins lag the counters by exactly one pixel. All three pins share that lag, so sync and colour stay aligned with each other.
- Between ticks, every register except d holds its value.
- No wider arithmetic is needed: all compares are 10-bit unsigned, and the counter maximums fit in 10 bits.

## Timing

- Reset values, taken at the next clk edge while reset = 1:
  - d = 0.
  - HCount = H_TOTAL-1 (799), VCount = V_TOTAL-1 (524).
  - video_on = 0, hsync = 1, vsync = 1, rgb = 0.
  - pixel_tick = 0 (with DIV = 1 it may be 1 combinationally once reset deasserts).
  - frame_start = 0.
- Because the counters reset to the end of the frame, the first tick after reset wraps them to (0,0) and pulses frame_start. No partial frame is emitted.
- Reset asserted mid-frame abandons the frame at the next edge. No residual sync pulse remains, since hsync and vsync return to 1.
- Pixel period is DIV clks, line is H_TOTAL*DIV clks, frame is H_TOTAL*V_TOTAL*DIV clks (840000 at DIV = 2).
- Latency from rgb_in to the rgb pin is one tick. Renderers must settle rgb_in within one pixel period of the HCount/VCount change.
- A counter update and the stage-1 pin update never happen on different edges.

## Test plan

- Reset release, DIV = 2:
  - Clk 0 after release: pixel_tick = 0. Clk 1: pixel_tick = 1 and frame_start = 1.
  - After that edge: HCount = 0, VCount = 0, video_on = 1, hsync = 1, vsync = 1, rgb = 0.
- Line timing: count ticks across one line. Expect 800 ticks per line, with hsync low for exactly 96 ticks. The first low pin cycle is the tick after HCount = 656 is presented.
- Frame timing: expect 525 lines per frame, vsync low for exactly 2 lines (1600 ticks), and frame_start exactly once per 840000 clks.
- Blanking and lag: hold rgb_in = 3'b111.
  - rgb = 111 for exactly 640 ticks per visible line, starting one tick after HCount = 0.
  - rgb = 0 at HCount 640..799 and at all lines >= 480.
- Reset mid-frame at (HCount 700, VCount 491), while hsync and vsync are both low: the next edge gives hsync = 1, vsync = 1, rgb = 0, HCount = 799, VCount = 524.
- DIV = 1 parameter variant: pixel_tick stays high continuously and HCount advances every clk. Line = 800 clks and hsync low for 96 clks.
